// File: rtl/datatypesPkg.sv
// Shared types for the alignment datapath: DNA bases, backtrace directions
// and the job-controller state encoding.
package datatypesPkg;

    typedef enum logic [1:0] {
        A = 2'd0,
        C = 2'd1,
        G = 2'd2,
        T = 2'd3
    } dna_base;

    typedef enum logic [1:0] {
        Nil  = 2'd0,
        Diag = 2'd1,
        Up   = 2'd2,
        Left = 2'd3
    } direction;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } ctrl_state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/cycle_timer.sv
// Up-counter that raises hit on reaching TERMINAL-1 and holds there until cleared.
module cycle_timer #(
    parameter int unsigned TERMINAL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic hit
);

    localparam int unsigned W = $clog2(TERMINAL) + 1;

    logic [W-1:0] count;

    // Saturating at the terminal count so the counter can never wrap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && !hit) begin
            count <= count + W'(1);
        end
    end

    assign hit = (count == W'(TERMINAL - 1));

endmodule

// File: rtl/align_job_controller.sv
// Job sequencer for one short_solver: accepts a sequence pair, pulses the
// solver reset, waits for finished (or a timeout) and returns a tagged result.
module align_job_controller
    import datatypesPkg::*;
#(
    parameter int unsigned len1           = 5,
    parameter int unsigned len2           = 5,
    parameter int unsigned ID_W           = 8,
    parameter int unsigned RST_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [ID_W-1:0]              job_id,
    input  dna_base [len1-1:0]           job_seq1,
    input  dna_base [len2-1:0]           job_seq2,
    output logic                         solver_rst,
    output dna_base [len1-1:0]           solver_seq1,
    output dna_base [len2-1:0]           solver_seq2,
    input  logic                         solver_finished,
    input  logic [$clog2(len1):0]        solver_max_row,
    input  logic [$clog2(len2):0]        solver_max_col,
    input  direction [len1+len2-1:0]     solver_aligned,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [ID_W-1:0]              res_id,
    output logic [$clog2(len1):0]        res_max_row,
    output logic [$clog2(len2):0]        res_max_col,
    output direction [len1+len2-1:0]     res_aligned,
    output logic                         res_timeout,
    output logic                         busy,
    output logic [15:0]                  jobs_done
);

    ctrl_state_t              state;
    logic [ID_W-1:0]          id_q;
    dna_base [len1-1:0]       seq1_q;
    dna_base [len2-1:0]       seq2_q;
    logic                     timer_clear;
    logic                     load_en;
    logic                     run_en;
    logic                     load_hit;
    logic                     run_hit;

    assign job_ready   = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);
    assign solver_seq1 = seq1_q;
    assign solver_seq2 = seq2_q;

    assign timer_clear = (state == IDLE);
    assign load_en     = (state == LOAD);
    assign run_en      = (state == RUN);

    cycle_timer #(.TERMINAL(RST_CYCLES)) u_load_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .en    (load_en),
        .hit   (load_hit)
    );

    cycle_timer #(.TERMINAL(TIMEOUT_CYCLES)) u_run_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .en    (run_en),
        .hit   (run_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            solver_rst  <= 1'b1;
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
            res_id      <= '0;
            res_max_row <= '0;
            res_max_col <= '0;
            jobs_done   <= '0;
            id_q        <= '0;
            for (int unsigned i = 0; i < len1; i++) seq1_q[i] <= A;
            for (int unsigned i = 0; i < len2; i++) seq2_q[i] <= A;
            for (int unsigned i = 0; i < len1 + len2; i++) res_aligned[i] <= Nil;
        end else begin
            unique case (state)
                IDLE: begin
                    solver_rst <= 1'b1;
                    if (job_valid && job_ready) begin
                        id_q   <= job_id;
                        seq1_q <= job_seq1;
                        seq2_q <= job_seq2;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_hit) begin
                        solver_rst <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // finished takes priority over a coincident timeout
                    if (solver_finished) begin
                        res_id      <= id_q;
                        res_max_row <= solver_max_row;
                        res_max_col <= solver_max_col;
                        res_aligned <= solver_aligned;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        solver_rst  <= 1'b1;
                        state       <= DONE;
                    end else if (run_hit) begin
                        res_id      <= id_q;
                        res_max_row <= '0;
                        res_max_col <= '0;
                        for (int unsigned i = 0; i < len1 + len2; i++) res_aligned[i] <= Nil;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        solver_rst  <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        jobs_done <= jobs_done + 16'd1;
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_align_job_controller.sv
// Directed bench for align_job_controller with a behavioural short_solver stub.
module tb_align_job_controller;
    import datatypesPkg::*;

    localparam int unsigned L1   = 5;
    localparam int unsigned L2   = 5;
    localparam int unsigned ID_W = 8;
    localparam int unsigned RSTC = 2;
    localparam int unsigned TO   = 32;
    localparam int unsigned AL   = L1 + L2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   job_valid;
    logic                   job_ready;
    logic [ID_W-1:0]        job_id;
    dna_base [L1-1:0]       job_seq1;
    dna_base [L2-1:0]       job_seq2;
    logic                   solver_rst;
    dna_base [L1-1:0]       solver_seq1;
    dna_base [L2-1:0]       solver_seq2;
    logic                   solver_finished;
    logic [$clog2(L1):0]    solver_max_row;
    logic [$clog2(L2):0]    solver_max_col;
    direction [AL-1:0]      solver_aligned;
    logic                   res_valid;
    logic                   res_ready;
    logic [ID_W-1:0]        res_id;
    logic [$clog2(L1):0]    res_max_row;
    logic [$clog2(L2):0]    res_max_col;
    direction [AL-1:0]      res_aligned;
    logic                   res_timeout;
    logic                   busy;
    logic [15:0]            jobs_done;

    int checks = 0;
    int errors = 0;

    // Solver stub: raises finished stub_delay edges after solver_rst falls.
    int                  stub_delay = -1;
    int                  stub_cnt   = 0;
    logic                stub_fin   = 1'b0;
    logic                stub_force = 1'b0;
    logic [$clog2(L1):0] stub_row;
    logic [$clog2(L2):0] stub_col;
    direction [AL-1:0]   stub_aligned;
    direction [AL-1:0]   nil_vec;

    assign solver_finished = stub_fin | stub_force;
    assign solver_max_row  = stub_row;
    assign solver_max_col  = stub_col;
    assign solver_aligned  = stub_aligned;

    always @(posedge clk) begin
        if (solver_rst) begin
            stub_cnt <= 0;
            stub_fin <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_delay > 0 && stub_cnt + 1 == stub_delay) stub_fin <= 1'b1;
        end
    end

    always #5 clk = ~clk;

    align_job_controller #(
        .len1           (L1),
        .len2           (L2),
        .ID_W           (ID_W),
        .RST_CYCLES     (RSTC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_id          (job_id),
        .job_seq1        (job_seq1),
        .job_seq2        (job_seq2),
        .solver_rst      (solver_rst),
        .solver_seq1     (solver_seq1),
        .solver_seq2     (solver_seq2),
        .solver_finished (solver_finished),
        .solver_max_row  (solver_max_row),
        .solver_max_col  (solver_max_col),
        .solver_aligned  (solver_aligned),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_id          (res_id),
        .res_max_row     (res_max_row),
        .res_max_col     (res_max_col),
        .res_aligned     (res_aligned),
        .res_timeout     (res_timeout),
        .busy            (busy),
        .jobs_done       (jobs_done)
    );

    function automatic direction dir_pat(input int unsigned k);
        unique case (k % 4)
            0:       return Diag;
            1:       return Up;
            2:       return Left;
            default: return Nil;
        endcase
    endfunction

    task automatic set_pattern(input int unsigned off);
        for (int unsigned i = 0; i < AL; i++) stub_aligned[i] = dir_pat(i + off);
    endtask

    task automatic set_seqs(input dna_base a0, a1, a2, a3, a4,
                            input dna_base b0, b1, b2, b3, b4);
        job_seq1[0] = a0; job_seq1[1] = a1; job_seq1[2] = a2; job_seq1[3] = a3; job_seq1[4] = a4;
        job_seq2[0] = b0; job_seq2[1] = b1; job_seq2[2] = b2; job_seq2[3] = b3; job_seq2[4] = b4;
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic accept_job(input logic [ID_W-1:0] id);
        int unsigned n;
        n = 0;
        job_id    = id;
        job_valid = 1'b1;
        while (!job_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_result(output int unsigned n);
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; job_valid = 1'b0; res_ready = 1'b0; job_id = '0;
        set_seqs(A, A, A, A, A, A, A, A, A, A);
        repeat (3) @(negedge clk);
        checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL reset_job_ready: got %b expected 0", job_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (solver_rst !== 1'b1) begin errors++; $display("FAIL reset_solver_rst: got %b expected 1", solver_rst); end
        checks++; if (res_valid !== 1'b0 || res_timeout !== 1'b0) begin errors++; $display("FAIL reset_res_flags: got valid=%b timeout=%b expected 0/0", res_valid, res_timeout); end
        checks++; if (res_id !== 8'h00 || res_max_row !== 3'd0 || res_max_col !== 3'd0) begin errors++; $display("FAIL reset_res_fields: got id=%h row=%0d col=%0d expected 0", res_id, res_max_row, res_max_col); end
        checks++; if (res_aligned !== nil_vec) begin errors++; $display("FAIL reset_aligned: got %h expected %h", res_aligned, nil_vec); end
        checks++; if (jobs_done !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_counters: got jobs_done=%0d busy=%b expected 0/0", jobs_done, busy); end
        checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", job_ready); end
        checks++; if (solver_seq1 !== job_seq1 || solver_seq2 !== job_seq2) begin errors++; $display("FAIL reset_seq_regs: got %h/%h expected 0", solver_seq1, solver_seq2); end
    endtask

    task automatic test_single_job();
        int unsigned n;
        dna_base [L1-1:0] e1;
        dna_base [L2-1:0] e2;
        stub_delay = 20; stub_row = 3'd4; stub_col = 3'd4; set_pattern(0);
        set_seqs(C, A, G, T, A, G, C, A, T, A);
        e1 = job_seq1; e2 = job_seq2;
        accept_job(8'h3C);
        checks++; if (busy !== 1'b1 || job_ready !== 1'b0) begin errors++; $display("FAIL single_accept: got busy=%b ready=%b expected 1/0", busy, job_ready); end
        checks++; if (solver_seq1 !== e1 || solver_seq2 !== e2) begin errors++; $display("FAIL single_seq: got %h/%h expected %h/%h", solver_seq1, solver_seq2, e1, e2); end
        checks++; if (solver_rst !== 1'b1) begin errors++; $display("FAIL single_rst_c1: got %b expected 1", solver_rst); end
        @(negedge clk);
        checks++; if (solver_rst !== 1'b1) begin errors++; $display("FAIL single_rst_c2: got %b expected 1", solver_rst); end
        @(negedge clk);
        checks++; if (solver_rst !== 1'b0) begin errors++; $display("FAIL single_rst_low: got %b expected 0", solver_rst); end
        wait_result(n);
        checks++; if (n !== 21) begin errors++; $display("FAIL single_latency: got %0d expected 21", n); end
        checks++; if (res_id !== 8'h3C || res_max_row !== 3'd4 || res_max_col !== 3'd4) begin errors++; $display("FAIL single_fields: got id=%h row=%0d col=%0d expected 3c/4/4", res_id, res_max_row, res_max_col); end
        checks++; if (res_aligned !== stub_aligned) begin errors++; $display("FAIL single_aligned: got %h expected %h", res_aligned, stub_aligned); end
        checks++; if (res_timeout !== 1'b0 || solver_rst !== 1'b1) begin errors++; $display("FAIL single_done_flags: got timeout=%b solver_rst=%b expected 0/1", res_timeout, solver_rst); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || jobs_done !== 16'd1 || job_ready !== 1'b1) begin errors++; $display("FAIL single_handshake: got valid=%b jobs_done=%0d ready=%b expected 0/1/1", res_valid, jobs_done, job_ready); end
    endtask

    task automatic test_timeout();
        int unsigned n;
        stub_delay = -1; stub_row = 3'd2; stub_col = 3'd2; set_pattern(1);
        set_seqs(T, T, T, T, T, G, G, G, G, G);
        accept_job(8'h11);
        repeat (2) @(negedge clk);
        wait_result(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL timeout_latency: got %0d expected 32", n); end
        checks++; if (res_timeout !== 1'b1 || res_id !== 8'h11) begin errors++; $display("FAIL timeout_flag: got timeout=%b id=%h expected 1/11", res_timeout, res_id); end
        checks++; if (res_max_row !== 3'd0 || res_max_col !== 3'd0 || res_aligned !== nil_vec) begin errors++; $display("FAIL timeout_fields: got row=%0d col=%0d al=%h expected 0/0/%h", res_max_row, res_max_col, res_aligned, nil_vec); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++; if (jobs_done !== 16'd2 || job_ready !== 1'b1) begin errors++; $display("FAIL timeout_handshake: got jobs_done=%0d ready=%b expected 2/1", jobs_done, job_ready); end
    endtask

    task automatic test_back_to_back();
        logic [ID_W-1:0]  ids [3];
        dna_base [L1-1:0] s1 [3];
        dna_base [L2-1:0] s2 [3];
        int unsigned      n;
        logic             ready_bad, seq_bad;
        ids[0] = 8'h21; ids[1] = 8'h22; ids[2] = 8'h23;
        set_seqs(A, A, C, C, G, T, T, G, G, C); s1[0] = job_seq1; s2[0] = job_seq2;
        set_seqs(G, T, A, C, A, C, A, T, T, G); s1[1] = job_seq1; s2[1] = job_seq2;
        set_seqs(T, G, C, A, T, A, G, C, T, A); s1[2] = job_seq1; s2[2] = job_seq2;
        stub_delay = 5; res_ready = 1'b1;
        job_id = ids[0]; job_seq1 = s1[0]; job_seq2 = s2[0]; job_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_%0d: got busy=%b expected 1", k, busy); end
            if (k < 2) begin
                job_id = ids[k+1]; job_seq1 = s1[k+1]; job_seq2 = s2[k+1];
            end else begin
                job_valid = 1'b0;
            end
            ready_bad = 1'b0; seq_bad = 1'b0; n = 0;
            while (!res_valid && n < 100) begin
                if (job_ready) ready_bad = 1'b1;
                if (solver_seq1 !== s1[k] || solver_seq2 !== s2[k]) seq_bad = 1'b1;
                @(negedge clk);
                n++;
            end
            checks++; if (res_valid !== 1'b1 || res_id !== ids[k]) begin errors++; $display("FAIL b2b_result_%0d: got valid=%b id=%h expected 1/%h", k, res_valid, res_id, ids[k]); end
            checks++; if (ready_bad !== 1'b0 || job_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low_%0d: got early_ready=%b ready=%b expected 0/0", k, ready_bad, job_ready); end
            checks++; if (seq_bad !== 1'b0 || solver_seq1 !== s1[k]) begin errors++; $display("FAIL b2b_seq_stable_%0d: got changed=%b expected 0", k, seq_bad); end
            @(negedge clk);
            checks++; if (job_ready !== 1'b1 || jobs_done !== 16'(3 + k)) begin errors++; $display("FAIL b2b_turnaround_%0d: got ready=%b jobs_done=%0d expected 1/%0d", k, job_ready, jobs_done, 3 + k); end
            @(negedge clk);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int unsigned       n;
        direction [AL-1:0] exp_al;
        logic              stable_bad, rst_bad, jd_bad;
        stub_delay = 3; stub_row = 3'd2; stub_col = 3'd3; set_pattern(2);
        exp_al = stub_aligned;
        set_seqs(C, C, C, A, A, T, A, T, A, T);
        accept_job(8'h44);
        repeat (2) @(negedge clk);
        wait_result(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", n); end
        stub_row = 3'd1; stub_col = 3'd0; stub_aligned = nil_vec;
        stable_bad = 1'b0; rst_bad = 1'b0; jd_bad = 1'b0;
        repeat (10) begin
            if (res_valid !== 1'b1 || res_id !== 8'h44 || res_max_row !== 3'd2 || res_max_col !== 3'd3 ||
                res_aligned !== exp_al || res_timeout !== 1'b0) stable_bad = 1'b1;
            if (solver_rst !== 1'b1) rst_bad = 1'b1;
            if (jobs_done !== 16'd5) jd_bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (stable_bad !== 1'b0) begin errors++; $display("FAIL bp_res_stable: got unstable=%b row=%0d col=%0d expected stable 2/3", stable_bad, res_max_row, res_max_col); end
        checks++; if (rst_bad !== 1'b0) begin errors++; $display("FAIL bp_solver_rst: got dropped=%b expected 0", rst_bad); end
        checks++; if (jd_bad !== 1'b0) begin errors++; $display("FAIL bp_jobs_done_hold: got jobs_done=%0d expected 5", jobs_done); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++; if (jobs_done !== 16'd6 || res_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake: got jobs_done=%0d valid=%b expected 6/0", jobs_done, res_valid); end
    endtask

    task automatic test_stale_finished();
        int unsigned n;
        stub_delay = 31; stub_row = 3'd3; stub_col = 3'd1; set_pattern(3);
        stub_force = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL stale_idle: got busy=%b valid=%b expected 0/0", busy, res_valid); end
        set_seqs(G, G, A, A, C, C, T, T, A, G);
        accept_job(8'h5A);
        repeat (2) @(negedge clk);
        stub_force = 1'b0;
        checks++; if (res_valid !== 1'b0 || solver_rst !== 1'b0) begin errors++; $display("FAIL stale_load: got valid=%b solver_rst=%b expected 0/0", res_valid, solver_rst); end
        wait_result(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL coincident_latency: got %0d expected 32", n); end
        checks++; if (res_timeout !== 1'b0 || res_id !== 8'h5A) begin errors++; $display("FAIL coincident_flag: got timeout=%b id=%h expected 0/5a", res_timeout, res_id); end
        checks++; if (res_max_row !== 3'd3 || res_max_col !== 3'd1 || res_aligned !== stub_aligned) begin errors++; $display("FAIL coincident_fields: got row=%0d col=%0d al=%h expected 3/1/%h", res_max_row, res_max_col, res_aligned, stub_aligned); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++; if (jobs_done !== 16'd7) begin errors++; $display("FAIL coincident_handshake: got jobs_done=%0d expected 7", jobs_done); end
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        stub_delay = -1;
        set_seqs(A, C, G, T, A, T, G, C, A, T);
        accept_job(8'h66);
        repeat (7) @(negedge clk);
        checks++; if (busy !== 1'b1 || solver_rst !== 1'b0) begin errors++; $display("FAIL midrst_running: got busy=%b solver_rst=%b expected 1/0", busy, solver_rst); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || solver_rst !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL midrst_state: got busy=%b solver_rst=%b valid=%b expected 0/1/0", busy, solver_rst, res_valid); end
        checks++; if (jobs_done !== 16'd0 || job_ready !== 1'b0) begin errors++; $display("FAIL midrst_counts: got jobs_done=%0d ready=%b expected 0/0", jobs_done, job_ready); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || job_ready !== 1'b1) begin errors++; $display("FAIL midrst_no_result: got result_seen=%b ready=%b expected 0/1", seen, job_ready); end
    endtask

    initial begin
        for (int unsigned i = 0; i < AL; i++) nil_vec[i] = Nil;
        set_pattern(0);
        stub_row = '0;
        stub_col = '0;
        @(negedge clk);
        test_reset();
        test_single_job();
        test_timeout();
        test_back_to_back();
        test_backpressure();
        test_stale_finished();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
